// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue sequencer driving the 8-bit ALU with a 4x8 register file
module alu_issue_ctrl #(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] REG_RESET = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_data1,
   output logic [DATA_W-1:0] alu_data2,
   output logic [1:0]        alu_opcode,
   output logic              alu_cs,
   input  logic [DATA_W-1:0] alu_result,
   output logic              wb_valid,
   output logic [1:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              illegal,
   output logic              busy,
   input  logic [1:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   // Sequencer states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_WB     = 2'd3;

   // Instruction classes, bits [15:14]
   localparam logic [1:0] CLS_ALU   = 2'b00;
   localparam logic [1:0] CLS_LOADI = 2'b01;
   localparam logic [1:0] CLS_NOP   = 2'b10;
   localparam logic [1:0] CLS_RSVD  = 2'b11;

   logic [1:0]        state_q,     state_d;
   logic [15:0]       instr_q,     instr_d;
   logic              alu_cs_q,    alu_cs_d;
   logic [DATA_W-1:0] alu_data1_q, alu_data1_d;
   logic [DATA_W-1:0] alu_data2_q, alu_data2_d;
   logic [1:0]        alu_op_q,    alu_op_d;
   logic              wb_valid_q,  wb_valid_d;
   logic [1:0]        wb_addr_q,   wb_addr_d;
   logic [DATA_W-1:0] wb_data_q,   wb_data_d;
   logic [DATA_W-1:0] regs_q [4];

   // Fields of the latched instruction
   logic [1:0]        f_cls;
   logic [1:0]        f_op;
   logic [1:0]        f_rd;
   logic [1:0]        f_rs1;
   logic [1:0]        f_rs2;
   logic [DATA_W-1:0] f_imm;
   logic              transfer;

   assign f_cls = instr_q[15:14];
   assign f_op  = instr_q[13:12];
   assign f_rd  = instr_q[11:10];
   assign f_rs1 = instr_q[9:8];
   assign f_rs2 = instr_q[7:6];
   assign f_imm = instr_q[DATA_W-1:0];

   assign instr_ready = (state_q == ST_IDLE) && !rst;
   assign transfer    = instr_valid && instr_ready;

   assign busy       = (state_q != ST_IDLE);
   assign illegal    = (state_q == ST_DECODE) && (f_cls == CLS_RSVD);
   assign alu_cs     = alu_cs_q;
   assign alu_data1  = alu_data1_q;
   assign alu_data2  = alu_data2_q;
   assign alu_opcode = alu_op_q;
   assign wb_valid   = wb_valid_q;
   assign wb_addr    = wb_addr_q;
   assign wb_data    = wb_data_q;
   assign dbg_data   = regs_q[dbg_addr];

   // Next-state logic; ALU select and write-back strobes are one-cycle by default
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      alu_cs_d    = 1'b1;
      alu_data1_d = alu_data1_q;
      alu_data2_d = alu_data2_q;
      alu_op_d    = alu_op_q;
      wb_valid_d  = 1'b0;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;

      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               instr_d = instr;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            case (f_cls)
               CLS_ALU: begin
                  // Operands are registered here so they are stable for the whole EXEC cycle
                  state_d     = ST_EXEC;
                  alu_cs_d    = 1'b0;
                  alu_data1_d = regs_q[f_rs1];
                  alu_data2_d = regs_q[f_rs2];
                  alu_op_d    = f_op;
               end
               CLS_LOADI: begin
                  state_d    = ST_WB;
                  wb_valid_d = 1'b1;
                  wb_addr_d  = f_rd;
                  wb_data_d  = f_imm;
               end
               CLS_NOP: begin
                  state_d = ST_IDLE;
               end
               default: begin
                  // Reserved class: illegal is flagged combinationally during this cycle
                  state_d = ST_IDLE;
               end
            endcase
         end

         ST_EXEC: begin
            // wb_data_q doubles as the ALU result register
            state_d    = ST_WB;
            wb_valid_d = 1'b1;
            wb_addr_d  = f_rd;
            wb_data_d  = alu_result;
         end

         ST_WB: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         instr_q     <= 16'h0000;
         alu_cs_q    <= 1'b1;
         alu_data1_q <= '0;
         alu_data2_q <= '0;
         alu_op_q    <= 2'b00;
         wb_valid_q  <= 1'b0;
         wb_addr_q   <= 2'b00;
         wb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         alu_cs_q    <= alu_cs_d;
         alu_data1_q <= alu_data1_d;
         alu_data2_q <= alu_data2_d;
         alu_op_q    <= alu_op_d;
         wb_valid_q  <= wb_valid_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
      end
   end

   // Register file: written at the end of the WB cycle, reloaded on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= REG_RESET;
         end
      end else if (wb_valid_q) begin
         regs_q[wb_addr_q] <= wb_data_q;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = 16'h0000;
   logic [7:0]  alu_data1, alu_data2, alu_result;
   logic [1:0]  alu_opcode;
   logic        alu_cs;
   logic        wb_valid;
   logic [1:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        illegal, busy;
   logic [1:0]  dbg_addr = 2'd0;
   logic [7:0]  dbg_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   bit rand_dbg = 1'b0;

   alu_issue_ctrl #(.DATA_W(8), .REG_RESET(8'h00)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_opcode(alu_opcode), .alu_cs(alu_cs),
      .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .illegal(illegal), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'b00:   return 8'(a + b);
         2'b01:   return 8'(a - b);
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // ALU stand-in: returns junk whenever it is not selected
   logic [7:0] junk = 8'h00;
   always @(posedge clk) junk <= 8'($urandom);
   assign alu_result = alu_cs ? junk : alu_f(alu_opcode, alu_data1, alu_data2);

   always @(posedge clk) if (rand_dbg) begin #2 dbg_addr = 2'($urandom); end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one instruction in flight, timed from its accept edge
   logic [7:0] m_regs [4];
   bit         m_active = 1'b0;
   int         m_start = 0;
   int         m_lat = 0;
   logic [1:0] m_cls, m_op, m_rd;
   logic [7:0] m_a, m_b, m_val;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
         m_active = 1'b0;
      end else if (!m_active) begin
         if (instr_valid) begin
            m_active = 1'b1;
            m_start  = cyc;
            m_cls    = instr[15:14];
            m_op     = instr[13:12];
            m_rd     = instr[11:10];
            m_a      = m_regs[instr[9:8]];
            m_b      = m_regs[instr[7:6]];
            case (m_cls)
               2'b00:   begin m_lat = 4; m_val = alu_f(m_op, m_a, m_b); end
               2'b01:   begin m_lat = 3; m_val = instr[7:0]; end
               default: begin m_lat = 2; m_val = 8'h00; end
            endcase
         end
      end else if (cyc - m_start == m_lat - 1) begin
         if (!m_cls[1]) m_regs[m_rd] = m_val;
         m_active = 1'b0;
      end
   end

   // Per-cycle comparison against the model, plus event capture for literal checks
   int         cnt_wb = 0, cnt_ill = 0, cnt_exec = 0;
   logic [7:0] last_wb_data = 8'h00, last_d1 = 8'h00, last_d2 = 8'h00;
   logic [1:0] last_wb_addr = 2'd0, last_op = 2'd0;

   always @(negedge clk) begin : cmp
      int d;
      bit e_cs0, e_wb, e_ill;
      if (chk_en) begin
         d     = cyc - m_start;
         e_cs0 = m_active && (m_cls == 2'b00) && (d == 1);
         e_wb  = m_active && !m_cls[1] && (d == m_lat - 2);
         e_ill = m_active && (m_cls == 2'b11) && (d == 0);
         chk("busy", 32'(busy), 32'(m_active));
         chk("instr_ready", 32'(instr_ready), 32'(!m_active && !rst));
         chk("alu_cs", 32'(alu_cs), 32'(!e_cs0));
         if (e_cs0) begin
            chk("alu_data1", 32'(alu_data1), 32'(m_a));
            chk("alu_data2", 32'(alu_data2), 32'(m_b));
            chk("alu_opcode", 32'(alu_opcode), 32'(m_op));
         end
         chk("wb_valid", 32'(wb_valid), 32'(e_wb));
         if (e_wb) begin
            chk("wb_addr", 32'(wb_addr), 32'(m_rd));
            chk("wb_data", 32'(wb_data), 32'(m_val));
         end
         chk("illegal", 32'(illegal), 32'(e_ill));
         chk("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
      end
      if (wb_valid === 1'b1) begin cnt_wb++; last_wb_addr = wb_addr; last_wb_data = wb_data; end
      if (illegal === 1'b1) cnt_ill++;
      if (alu_cs === 1'b0) begin cnt_exec++; last_d1 = alu_data1; last_d2 = alu_data2; last_op = alu_opcode; end
   end

   // Present a word and hold it until accepted; returns just after the accept edge
   task automatic issue(input logic [15:0] w);
      int n = 0;
      instr_valid = 1'b1;
      instr = w;
      @(negedge clk);
      while (!instr_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL issue_timeout: instr_ready stayed %0b for %0d cycles, required 1", instr_ready, n);
      end
      @(posedge clk); #1;
   endtask

   // Issue one word alone and measure accept-to-ready in cycles
   task automatic run(input logic [15:0] w, input int lat, input string nm);
      int k = 0;
      issue(w);
      instr_valid = 1'b0;
      instr = 16'($urandom);
      do begin @(negedge clk); k++; end while (!instr_ready && k < 20);
      chk({nm, "_latency"}, 32'(k), 32'(lat));
      @(posedge clk); #1;
   endtask

   task automatic dbg_check(input logic [1:0] a, input logic [7:0] e);
      @(posedge clk); #2;
      dbg_addr = a;
      #1;
      chk($sformatf("dbg_r%0d", a), 32'(dbg_data), 32'(e));
      chk($sformatf("model_r%0d", a), 32'(m_regs[a]), 32'(e));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cw, ci, ce, t0, g;
      logic [15:0] w;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_cs", 32'(alu_cs), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_data1", 32'(alu_data1), 32'd0);
      chk("rst_data2", 32'(alu_data2), 32'd0);
      chk("rst_opcode", 32'(alu_opcode), 32'd0);
      chk("rst_wb_addr", 32'(wb_addr), 32'd0);
      chk("rst_wb_data", 32'(wb_data), 32'd0);
      for (int a = 0; a < 4; a++) dbg_check(2'(a), 8'h00);

      // LOADI r1=05, r2=03
      cw = cnt_wb;
      run(16'h4405, 3, "loadi_r1");
      chk("wb_r1_addr", 32'(last_wb_addr), 32'd1);
      chk("wb_r1_data", 32'(last_wb_data), 32'h05);
      run(16'h4803, 3, "loadi_r2");
      chk("wb_r2_addr", 32'(last_wb_addr), 32'd2);
      chk("wb_r2_data", 32'(last_wb_data), 32'h03);
      chk("loadi_wb_count", 32'(cnt_wb - cw), 32'd2);
      dbg_check(2'd1, 8'h05);
      dbg_check(2'd2, 8'h03);

      // add r3 = r1 + r2, sub r0 = r2 - r1
      ce = cnt_exec;
      run(16'h0D80, 4, "add");
      chk("add_exec_cycles", 32'(cnt_exec - ce), 32'd1);
      chk("add_data1", 32'(last_d1), 32'h05);
      chk("add_data2", 32'(last_d2), 32'h03);
      chk("add_opcode", 32'(last_op), 32'd0);
      dbg_check(2'd3, 8'h08);
      run(16'h1240, 4, "sub");
      dbg_check(2'd0, 8'hFE);

      // and/or with rd == rs1
      run(16'h44F0, 3, "loadi_f0");
      run(16'h483C, 3, "loadi_3c");
      run(16'h2580, 4, "and");
      dbg_check(2'd1, 8'h30);
      run(16'h3580, 4, "or");
      dbg_check(2'd1, 8'h3C);

      // NOP then reserved
      cw = cnt_wb; ci = cnt_ill;
      run(16'h8000, 2, "nop");
      chk("nop_illegal", 32'(cnt_ill - ci), 32'd0);
      run(16'hC000, 2, "rsvd");
      chk("rsvd_illegal", 32'(cnt_ill - ci), 32'd1);
      chk("nop_rsvd_wb", 32'(cnt_wb - cw), 32'd0);

      // Back-to-back: held valid is taken on the first IDLE cycle
      issue(16'h4011);
      t0 = cyc;
      issue(16'h8000);
      chk("b2b_loadi_gap", 32'(cyc - t0), 32'd3);
      t0 = cyc;
      issue(16'h0D80);
      chk("b2b_nop_gap", 32'(cyc - t0), 32'd2);
      t0 = cyc;
      issue(16'h8000);
      chk("b2b_alu_gap", 32'(cyc - t0), 32'd4);
      instr_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end

      // Reset during EXEC of an add
      cw = cnt_wb;
      issue(16'h0D80);
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("exec_cs_before_rst", 32'(alu_cs), 32'd0);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      #1;
      chk("post_rst_cs", 32'(alu_cs), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
      for (int a = 0; a < 4; a++) dbg_check(2'(a), 8'h00);
      chk("rst_drop_wb", 32'(cnt_wb - cw), 32'd0);

      // Randomized program
      rand_dbg = 1'b1;
      repeat (300) begin
         w = 16'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: w[15:14] = 2'b00;
            5, 6, 7:       w[15:14] = 2'b01;
            8:             w[15:14] = 2'b10;
            default:       w[15:14] = 2'b11;
         endcase
         g = $urandom_range(0, 2);
         if (g != 0) begin
            instr_valid = 1'b0;
            instr = 16'($urandom);
            repeat (g) begin @(posedge clk); #1; end
         end
         issue(w);
      end
      instr_valid = 1'b0;
      repeat (6) @(posedge clk);
      rand_dbg = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
